ft_spi_tunnel_enc: RTL and testbench

Host-side encoder for the two-wire SPI tunnel carried on the FT2232C UART pins. It turns byte transactions into the TXD/RTS waveform that the bridge decodes into SPI CS/SCK/MOSI. It also samples the MISO echo returned on RXD. It emulates the FTDI bit-bang host in FPGA, for loopback tests and for driving the BT flash from local logic.
Encoding, decided:
- TXD falling selects (CS low).
- While selected, SCK = TXD and MOSI = RTS.
- While TXD is high, one RTS rise plus one RTS fall deselects.
- Idle is TXD=1, RTS=0 (SCK=0, MOSI=0). SPI mode 0, MSB first.

---
 rtl/ft_spi_tunnel_pkg.sv | 35 +++
 rtl/ft_spi_tunnel_enc_if.sv | 28 ++
 rtl/ft_spi_tunnel_enc_chk.sv | 17 +
 rtl/ft_spi_tunnel_enc_sync2.sv | 31 +++
 rtl/ft_spi_tunnel_enc.sv | 225 ++++++++++++++++++++++
 tb/tb_ft_spi_tunnel_enc.sv | 382 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ft_spi_tunnel_pkg.sv
// ---------------------------------------------------------------------------
// ft_spi_tunnel_pkg
// Shared types and constants for the host-side SPI tunnel encoder that
// drives the two-wire TXD/RTS waveform toward the FT2232C bridge.
// No ports (package).
// ---------------------------------------------------------------------------
package ft_spi_tunnel_pkg;

   // Encoder sequencing states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEL    = 3'd1,
      HIGH   = 3'd2,
      LOW    = 3'd3,
      WAIT   = 3'd4,
      DESEL0 = 3'd5,
      DESEL1 = 3'd6,
      DESEL2 = 3'd7
   } state_t;

   // Smallest half period that still leaves room for the MISO round trip
   // (bridge register + synchroniser) before the sample point.
   localparam int   MIN_HALF_PERIOD = 4;
   localparam int   SYNC_STAGES     = 2;

   // Line levels when nothing is selected: SCK=0, MOSI=0.
   localparam logic IDLE_TXD = 1'b1;
   localparam logic IDLE_RTS = 1'b0;

   // States in which a new byte may be accepted
   function automatic logic is_ready_state(input state_t s);
      return (s == IDLE) || (s == WAIT);
   endfunction

endpackage

// File: rtl/ft_spi_tunnel_enc_if.sv
// ---------------------------------------------------------------------------
// ft_spi_tunnel_enc_if
// Byte-level handshake between local logic and the tunnel encoder.
//   tx_data/tx_last/tx_valid : byte offered by the host logic
//   tx_ready                 : encoder can take a byte this cycle
//   rx_data/rx_valid         : byte captured from MISO, one-cycle pulse
//   busy                     : encoder is not idle
// Modports: master = host logic, slave = encoder.
// ---------------------------------------------------------------------------
interface ft_spi_tunnel_enc_if;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   modport master (
      output tx_data, tx_last, tx_valid,
      input  tx_ready, rx_data, rx_valid, busy
   );

   modport slave (
      input  tx_data, tx_last, tx_valid,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/ft_spi_tunnel_enc_chk.sv
// ---------------------------------------------------------------------------
// ft_spi_tunnel_enc_chk
// Elaboration-time parameter check for the tunnel encoder.
// No ports; HALF_PERIOD must allow the MISO path to settle.
// ---------------------------------------------------------------------------
module ft_spi_tunnel_enc_chk
   import ft_spi_tunnel_pkg::*;
#(
   parameter int HALF_PERIOD = 50
) ();

   if (HALF_PERIOD < MIN_HALF_PERIOD) begin : g_half_period_too_small
      $error("ft_spi_tunnel_enc: HALF_PERIOD=%0d is below the minimum of %0d",
             HALF_PERIOD, MIN_HALF_PERIOD);
   end

endmodule

// File: rtl/ft_spi_tunnel_enc_sync2.sv
// ---------------------------------------------------------------------------
// ft_sync2
// Flop-chain synchroniser for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset (chain clears to 0)
//   d   : asynchronous input
//   q   : synchronised output
// ---------------------------------------------------------------------------
module ft_sync2
   import ft_spi_tunnel_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages_r;

   // Shift the asynchronous bit through the synchroniser chain
   always_ff @(posedge clk) begin
      if (rst) begin
         stages_r <= '0;
      end else begin
         stages_r <= {stages_r[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages_r[SYNC_STAGES-1];

endmodule

// File: rtl/ft_spi_tunnel_enc.sv
// ---------------------------------------------------------------------------
// ft_spi_tunnel_enc
// Host-side encoder for the two-wire SPI tunnel on the FT2232C UART pins.
// A TXD fall selects the slave; while selected SCK=TXD and MOSI=RTS; an RTS
// rise followed by an RTS fall while TXD is high deselects. SPI mode 0,
// MSB first.
//   CLK100MHZ : system clock
//   RESET     : synchronous active-high reset
//   bus       : byte handshake (slave modport)
//   ENC_TXD   : encoded TXD toward the bridge (registered)
//   ENC_RTS   : encoded RTS toward the bridge (registered)
//   ENC_RXD   : MISO echo from the bridge (asynchronous)
// ---------------------------------------------------------------------------
module ft_spi_tunnel_enc
   import ft_spi_tunnel_pkg::*;
#(
   parameter int HALF_PERIOD = 50
)
(
   input  logic               CLK100MHZ,
   input  logic               RESET,
   ft_spi_tunnel_enc_if.slave bus,
   output logic               ENC_TXD,
   output logic               ENC_RTS,
   input  logic               ENC_RXD
);

   localparam int             CNT_W    = $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   state_t             state_r,    state_nx_s;
   logic [CNT_W-1:0]   cnt_r,      cnt_nx_s;
   logic [2:0]         bit_r,      bit_nx_s;
   logic [7:0]         byte_r,     byte_nx_s;
   logic               last_r,     last_nx_s;
   logic [7:0]         rx_shift_r, rx_shift_nx_s;
   logic [7:0]         rx_data_r,  rx_data_nx_s;
   logic               rx_valid_r, rx_valid_nx_s;
   logic               txd_r,      txd_nx_s;
   logic               rts_r,      rts_nx_s;
   logic               ready_r;
   logic               busy_r;
   logic               rxd_sync_s;
   logic               accept_s;
   logic               cnt_end_s;

   ft_spi_tunnel_enc_chk #(.HALF_PERIOD(HALF_PERIOD)) u_chk ();

   ft_sync2 u_rxd_sync (
      .clk (CLK100MHZ),
      .rst (RESET),
      .d   (ENC_RXD),
      .q   (rxd_sync_s)
   );

   assign accept_s  = bus.tx_valid & ready_r;
   assign cnt_end_s = (cnt_r == CNT_LAST);

   // Next-state, line levels and capture logic for the encoder FSM.
   // Line levels are computed for the next state so the registered outputs
   // always match the state being entered; RTS changes together with a TXD
   // fall and never while TXD is high inside a transaction.
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r + CNT_ONE;
      bit_nx_s      = bit_r;
      byte_nx_s     = byte_r;
      last_nx_s     = last_r;
      rx_shift_nx_s = rx_shift_r;
      rx_data_nx_s  = rx_data_r;
      rx_valid_nx_s = 1'b0;
      txd_nx_s      = IDLE_TXD;
      rts_nx_s      = rts_r;
      case (state_r)
         IDLE: begin
            cnt_nx_s = CNT_ZERO;
            rts_nx_s = IDLE_RTS;
            if (accept_s) begin
               byte_nx_s  = bus.tx_data;
               last_nx_s  = bus.tx_last;
               bit_nx_s   = 3'd7;
               state_nx_s = SEL;
               txd_nx_s   = 1'b0;
               rts_nx_s   = bus.tx_data[7];
            end else begin
               state_nx_s = IDLE;
            end
         end
         SEL: begin
            txd_nx_s = 1'b0;
            if (cnt_end_s) begin
               state_nx_s = HIGH;
               cnt_nx_s   = CNT_ZERO;
               txd_nx_s   = 1'b1;
            end else begin
               state_nx_s = SEL;
            end
         end
         HIGH: begin
            if (cnt_end_s) begin
               // MISO is sampled on the final cycle of the SCK-high phase
               cnt_nx_s      = CNT_ZERO;
               rx_shift_nx_s = {rx_shift_r[6:0], rxd_sync_s};
               if (bit_r != 3'd0) begin
                  state_nx_s = LOW;
                  bit_nx_s   = bit_r - 3'd1;
                  txd_nx_s   = 1'b0;
                  rts_nx_s   = byte_r[bit_r - 3'd1];
               end else begin
                  rx_data_nx_s  = {rx_shift_r[6:0], rxd_sync_s};
                  rx_valid_nx_s = 1'b1;
                  if (last_r) begin
                     state_nx_s = DESEL0;
                     rts_nx_s   = IDLE_RTS;
                  end else begin
                     state_nx_s = WAIT;
                  end
               end
            end else begin
               state_nx_s = HIGH;
            end
         end
         LOW: begin
            txd_nx_s = 1'b0;
            if (cnt_end_s) begin
               state_nx_s = HIGH;
               cnt_nx_s   = CNT_ZERO;
               txd_nx_s   = 1'b1;
            end else begin
               state_nx_s = LOW;
            end
         end
         WAIT: begin
            // CS stays asserted with SCK high for as long as the host stalls
            cnt_nx_s = CNT_ZERO;
            if (accept_s) begin
               byte_nx_s  = bus.tx_data;
               last_nx_s  = bus.tx_last;
               bit_nx_s   = 3'd7;
               state_nx_s = LOW;
               txd_nx_s   = 1'b0;
               rts_nx_s   = bus.tx_data[7];
            end else begin
               state_nx_s = WAIT;
            end
         end
         DESEL0: begin
            rts_nx_s = 1'b0;
            if (cnt_end_s) begin
               state_nx_s = DESEL1;
               cnt_nx_s   = CNT_ZERO;
               rts_nx_s   = 1'b1;
            end else begin
               state_nx_s = DESEL0;
            end
         end
         DESEL1: begin
            rts_nx_s = 1'b1;
            if (cnt_end_s) begin
               state_nx_s = DESEL2;
               cnt_nx_s   = CNT_ZERO;
               rts_nx_s   = 1'b0;
            end else begin
               state_nx_s = DESEL1;
            end
         end
         DESEL2: begin
            rts_nx_s = 1'b0;
            if (cnt_end_s) begin
               state_nx_s = IDLE;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = DESEL2;
            end
         end
         default: begin
            state_nx_s = DESEL0;
            cnt_nx_s   = CNT_ZERO;
            rts_nx_s   = IDLE_RTS;
         end
      endcase
   end

   // State and output registers; reset forces TXD high and restarts the
   // deselect sequence so an interrupted transaction is closed cleanly.
   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         state_r    <= DESEL0;
         cnt_r      <= CNT_ZERO;
         bit_r      <= 3'd7;
         byte_r     <= 8'h00;
         last_r     <= 1'b0;
         rx_shift_r <= 8'h00;
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         txd_r      <= IDLE_TXD;
         rts_r      <= IDLE_RTS;
         ready_r    <= 1'b0;
         busy_r     <= 1'b1;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         bit_r      <= bit_nx_s;
         byte_r     <= byte_nx_s;
         last_r     <= last_nx_s;
         rx_shift_r <= rx_shift_nx_s;
         rx_data_r  <= rx_data_nx_s;
         rx_valid_r <= rx_valid_nx_s;
         txd_r      <= txd_nx_s;
         rts_r      <= rts_nx_s;
         ready_r    <= is_ready_state(state_nx_s);
         busy_r     <= (state_nx_s != IDLE);
      end
   end

   assign ENC_TXD      = txd_r;
   assign ENC_RTS      = rts_r;
   assign bus.tx_ready = ready_r;
   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_ft_spi_tunnel_enc.sv
// ---------------------------------------------------------------------------
// tb_ft_spi_tunnel_enc
// Bench for ft_spi_tunnel_enc with a behavioural bridge + SPI slave that
// decodes TXD/RTS into CS/SCK/MOSI and returns MISO on ENC_RXD.
// ---------------------------------------------------------------------------
module tb_ft_spi_tunnel_enc;

   localparam int HP      = 4;
   localparam int TIMEOUT = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enc_txd, enc_rts;
   logic enc_rxd = 1'b0;

   ft_spi_tunnel_enc_if bus ();

   ft_spi_tunnel_enc #(.HALF_PERIOD(HP)) dut (
      .CLK100MHZ (clk),
      .RESET     (rst),
      .bus       (bus),
      .ENC_TXD   (enc_txd),
      .ENC_RTS   (enc_rts),
      .ENC_RXD   (enc_rxd)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural bridge / slave state
   int         cyc = 0;
   bit         sel = 1'b0;
   bit         seen_rts_rise = 1'b0;
   int         cur_rises = 0;
   int         bitcnt = 0;
   logic [7:0] mosi_sh = 8'h00;
   logic [7:0] miso_sh = 8'h00;
   logic       prev_txd = 1'b1;
   logic       prev_rts = 1'b0;
   logic [7:0] resp_q[$];
   logic [7:0] slave_rx[$];
   logic [7:0] rx_q[$];
   int         rx_cyc[$];
   int         win_q[$];

   // Bridge decoder, SPI slave and rx_valid monitor, evaluated 2 time units
   // after each rising edge so the encoder outputs have settled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (bus.rx_valid === 1'b1) begin
            rx_q.push_back(bus.rx_data);
            rx_cyc.push_back(cyc);
         end
         if (!sel) begin
            if (prev_txd === 1'b1 && enc_txd === 1'b0) begin
               sel = 1'b1;
               cur_rises = 0;
               bitcnt = 0;
               seen_rts_rise = 1'b0;
               miso_sh = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
               enc_rxd = miso_sh[7];
            end
         end else if (prev_txd === 1'b0 && enc_txd === 1'b1) begin
            mosi_sh = {mosi_sh[6:0], enc_rts};
            bitcnt++;
            cur_rises++;
            seen_rts_rise = 1'b0;
            if (bitcnt == 8) begin
               slave_rx.push_back(mosi_sh);
               bitcnt = 0;
            end
         end else if (prev_txd === 1'b1 && enc_txd === 1'b0) begin
            if (bitcnt == 0) miso_sh = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
            else             miso_sh = {miso_sh[6:0], 1'b0};
            enc_rxd = miso_sh[7];
         end else if (enc_txd === 1'b1) begin
            if (prev_rts === 1'b0 && enc_rts === 1'b1) begin
               seen_rts_rise = 1'b1;
            end else if (prev_rts === 1'b1 && enc_rts === 1'b0 && seen_rts_rise) begin
               sel = 1'b0;
               win_q.push_back(cur_rises);
            end
         end
         prev_txd = enc_txd;
         prev_rts = enc_rts;
      end
   end

   task automatic clear_model();
      resp_q.delete();
      slave_rx.delete();
      rx_q.delete();
      rx_cyc.delete();
      win_q.delete();
   endtask

   // Offer one byte (after an optional stall) and wait for it to be accepted
   task automatic drive_byte(input logic [7:0] d, input logic last, input int stall,
                             output int acc_cyc);
      int t;
      repeat (stall) @(negedge clk);
      bus.tx_data  = d;
      bus.tx_last  = last;
      bus.tx_valid = 1'b1;
      t = 0;
      while (bus.tx_ready !== 1'b1 && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= TIMEOUT) begin
         failures++;
         $display("FAIL accept_timeout: tx_ready=%b required 1 within %0d cycles", bus.tx_ready, TIMEOUT);
      end
      acc_cyc = cyc;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bus.busy !== 1'b0 && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= TIMEOUT) begin
         failures++;
         $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] got, exp;
      rst = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_last  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({enc_txd, enc_rts, bus.tx_ready, bus.rx_valid, bus.busy} !== 5'b10001 ||
          bus.rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_values: txd/rts/ready/rxv/busy=%b rx_data=%h required 10001 00",
                  {enc_txd, enc_rts, bus.tx_ready, bus.rx_valid, bus.busy}, bus.rx_data);
      end
      rst = 1'b0;
      // RTS 0,1,0 for HP cycles each with TXD high, then ready/idle at 3*HP
      for (int c = 0; c < 3 * HP + 2; c++) begin
         exp = {1'b1, (c >= HP && c < 2 * HP), (c >= 3 * HP), (c < 3 * HP)};
         got = {enc_txd, enc_rts, bus.tx_ready, bus.busy};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL desel_seq cycle %0d: txd/rts/ready/busy=%b required %b", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      int acc;
      clear_model();
      resp_q.push_back(8'h3C);
      drive_byte(8'hA5, 1'b1, 0, acc);
      wait_idle();
      checks++;
      if (slave_rx.size() != 1 || slave_rx[0] !== 8'hA5) begin
         failures++;
         $display("FAIL single_mosi: got %0d bytes first=%h required 1 byte a5",
                  slave_rx.size(), (slave_rx.size() > 0) ? slave_rx[0] : 8'h00);
      end
      checks++;
      if (win_q.size() != 1 || win_q[0] != 8 || sel) begin
         failures++;
         $display("FAIL single_cs: windows=%0d sel=%b required 1 window of 8 rises, deselected",
                  win_q.size(), sel);
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
         failures++;
         $display("FAIL single_rx: pulses=%0d data=%h required 1 pulse 3c",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      end
      checks++;
      if (rx_cyc.size() != 1 || rx_cyc[0] - acc != 16 * HP + 1) begin
         failures++;
         $display("FAIL single_latency: got %0d required %0d",
                  (rx_cyc.size() > 0) ? rx_cyc[0] - acc : -1, 16 * HP + 1);
      end
      checks++;
      if (enc_txd !== 1'b1 || enc_rts !== 1'b0 || bus.rx_data !== 8'h3C) begin
         failures++;
         $display("FAIL single_idle: txd=%b rts=%b rx_data=%h required 1 0 3c", enc_txd, enc_rts, bus.rx_data);
      end
   endtask

   task automatic test_burst();
      logic [7:0] tx[3]  = '{8'h9F, 8'h00, 8'h00};
      logic [7:0] rsp[3] = '{8'hEF, 8'h40, 8'h18};
      int acc;
      clear_model();
      for (int i = 0; i < 3; i++) resp_q.push_back(rsp[i]);
      for (int i = 0; i < 3; i++) drive_byte(tx[i], (i == 2), 0, acc);
      wait_idle();
      checks++;
      if (win_q.size() != 1 || win_q[0] != 24) begin
         failures++;
         $display("FAIL burst_cs: windows=%0d rises=%0d required 1 window of 24",
                  win_q.size(), (win_q.size() > 0) ? win_q[0] : -1);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (slave_rx.size() != 3 || rx_q.size() != 3 ||
             slave_rx[i] !== tx[i] || rx_q[i] !== rsp[i]) begin
            failures++;
            $display("FAIL burst_byte%0d: sizes %0d/%0d required 3/3, mosi/miso %h/%h required %h/%h", i,
                     slave_rx.size(), rx_q.size(),
                     (slave_rx.size() > i) ? slave_rx[i] : 8'h00,
                     (rx_q.size() > i) ? rx_q[i] : 8'h00, tx[i], rsp[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] b0 = 8'($urandom);
      logic [7:0] b1 = 8'($urandom);
      logic [7:0] r0 = 8'($urandom);
      logic [7:0] r1 = 8'($urandom);
      int acc, t;
      clear_model();
      resp_q.push_back(r0);
      resp_q.push_back(r1);
      drive_byte(b0, 1'b0, 0, acc);
      t = 0;
      while (bus.tx_ready !== 1'b1 && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      for (int c = 0; c < 40; c++) begin
         checks++;
         if (enc_txd !== 1'b1 || enc_rts !== b0[0] || !sel || bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold cycle %0d: txd=%b rts=%b cs_low=%b ready=%b required 1 %b 1 1",
                     c, enc_txd, enc_rts, sel, bus.tx_ready, b0[0]);
         end
         @(negedge clk);
      end
      drive_byte(b1, 1'b1, 0, acc);
      wait_idle();
      checks++;
      if (slave_rx.size() != 2 || slave_rx[0] !== b0 || slave_rx[1] !== b1 ||
          win_q.size() != 1 || win_q[0] != 16) begin
         failures++;
         $display("FAIL stall_mosi: bytes=%0d windows=%0d required %h %h in one 16-rise window",
                  slave_rx.size(), win_q.size(), b0, b1);
      end
      checks++;
      if (rx_q.size() != 2 || rx_q[0] !== r0 || rx_q[1] !== r1) begin
         failures++;
         $display("FAIL stall_rx: pulses=%0d required 2 bytes %h %h", rx_q.size(), r0, r1);
      end
   endtask

   task automatic test_last_one();
      logic [7:0] r = 8'($urandom);
      int acc;
      clear_model();
      resp_q.push_back(r);
      drive_byte(8'hFF, 1'b1, 0, acc);
      wait_idle();
      checks++;
      if (win_q.size() != 1 || win_q[0] != 8 || sel || enc_rts !== 1'b0 ||
          slave_rx.size() != 1 || slave_rx[0] !== 8'hFF) begin
         failures++;
         $display("FAIL last_one: windows=%0d sel=%b rts=%b bytes=%0d required 1 0 0 1(ff)",
                  win_q.size(), sel, enc_rts, slave_rx.size());
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== r) begin
         failures++;
         $display("FAIL last_one_rx: pulses=%0d required 1 byte %h", rx_q.size(), r);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b = 8'($urandom);
      logic [7:0] r = 8'($urandom);
      int acc, t;
      clear_model();
      resp_q.push_back(r);
      drive_byte(8'($urandom), 1'b1, 0, acc);
      t = 0;
      while (!(cur_rises == 3 && enc_txd === 1'b0) && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (enc_txd !== 1'b1 || bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_txd: txd=%b busy=%b ready=%b required 1 1 0", enc_txd, bus.busy, bus.tx_ready);
      end
      rst = 1'b0;
      wait_idle();
      checks++;
      if (rx_q.size() != 0 || slave_rx.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_partial: rx pulses=%0d slave bytes=%0d required 0 0", rx_q.size(), slave_rx.size());
      end
      checks++;
      if (sel || win_q.size() != 1 || win_q[0] != 4) begin
         failures++;
         $display("FAIL reset_mid_cs: sel=%b windows=%0d rises=%0d required 0 1 4",
                  sel, win_q.size(), (win_q.size() > 0) ? win_q[0] : -1);
      end
      clear_model();
      resp_q.push_back(r);
      drive_byte(b, 1'b1, 0, acc);
      wait_idle();
      checks++;
      if (slave_rx.size() != 1 || slave_rx[0] !== b || rx_q.size() != 1 || rx_q[0] !== r ||
          win_q.size() != 1 || win_q[0] != 8) begin
         failures++;
         $display("FAIL reset_mid_clean: bytes=%0d pulses=%0d windows=%0d required %h/%h in one 8-rise window",
                  slave_rx.size(), rx_q.size(), win_q.size(), b, r);
      end
   endtask

   task automatic test_random();
      for (int round = 0; round < 5; round++) begin
         int n = $urandom_range(1, 4);
         logic [7:0] tx[$];
         logic [7:0] rsp[$];
         int acc;
         clear_model();
         for (int i = 0; i < n; i++) begin
            tx.push_back(8'($urandom));
            rsp.push_back(8'($urandom));
            resp_q.push_back(rsp[i]);
         end
         for (int i = 0; i < n; i++) drive_byte(tx[i], (i == n - 1), $urandom_range(0, 80), acc);
         wait_idle();
         checks++;
         if (win_q.size() != 1 || win_q[0] != 8 * n || slave_rx.size() != n || rx_q.size() != n) begin
            failures++;
            $display("FAIL random%0d_shape: windows=%0d rises=%0d bytes=%0d pulses=%0d required 1 %0d %0d %0d",
                     round, win_q.size(), (win_q.size() > 0) ? win_q[0] : -1,
                     slave_rx.size(), rx_q.size(), 8 * n, n, n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (slave_rx[i] !== tx[i] || rx_q[i] !== rsp[i]) begin
                  failures++;
                  $display("FAIL random%0d_byte%0d: mosi/miso %h/%h required %h/%h",
                           round, i, slave_rx[i], rx_q[i], tx[i], rsp[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_stall();
      test_last_one();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
